// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: op codes, port count and FSM state encoding.
package alu_share_arbiter_pkg;

    localparam int NUM_PORTS = 2;
    localparam int OP_W      = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu_core.sv
// Purely combinational integer ALU; unsupported op codes yield zero with o_err set.
module alu_core
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] w_shamt;
    assign w_shamt = i_b[SH_W-1:0];

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            OP_SLTU: o_result = {{(WIDTH-1){1'b0}}, i_a < i_b};
            OP_SLL:  o_result = i_a << w_shamt;
            OP_SRA:  o_result = WIDTH'($signed(i_a) >>> w_shamt);
            OP_SRL:  o_result = i_a >> w_shamt;
            default: o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one ALU with a registered 1-cycle response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      req_valid,
    output logic [NUM_PORTS-1:0]      req_ready,
    input  logic [NUM_PORTS*OP_W-1:0] req_op,
    input  logic [NUM_PORTS*WIDTH-1:0] req_a,
    input  logic [NUM_PORTS*WIDTH-1:0] req_b,
    output logic [NUM_PORTS-1:0]      resp_valid,
    input  logic [NUM_PORTS-1:0]      resp_ready,
    output logic [WIDTH-1:0]          resp_result,
    output logic                      resp_zero,
    output logic                      resp_err
);

    arb_state_e r_state, w_state_nxt;
    logic       r_owner;
    logic       w_can_accept;
    logic       w_grant_vld;
    logic       w_grant;
    logic       w_winner;
    logic       w_accept;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;

    logic [OP_W-1:0]  w_op_arr [NUM_PORTS];
    logic [WIDTH-1:0] w_a_arr  [NUM_PORTS];
    logic [WIDTH-1:0] w_b_arr  [NUM_PORTS];
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign w_op_arr[gi] = req_op[gi*OP_W +: OP_W];
            assign w_a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
            assign w_b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_winner = 1'b0;
`else
    logic r_last_grant;
    // On a conflict, the port that did not win last time goes first.
    assign w_winner = ~r_last_grant;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_vld  = 1'b0;
        w_grant      = 1'b0;
        req_ready    = '0;
        resp_valid   = '0;
        w_can_accept = (r_state == ST_IDLE) || resp_ready[r_owner];

        case (req_valid)
            2'b01: begin w_grant_vld = 1'b1; w_grant = 1'b0;     end
            2'b10: begin w_grant_vld = 1'b1; w_grant = 1'b1;     end
            2'b11: begin w_grant_vld = 1'b1; w_grant = w_winner; end
            default: ;
        endcase

        // Reset gates ready so nothing is accepted while state is being cleared.
        if (w_can_accept && w_grant_vld && !reset)
            req_ready[w_grant] = 1'b1;
        w_accept = |req_ready;

        if (r_state == ST_RESP)
            resp_valid[r_owner] = 1'b1;

        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (w_accept)                w_state_nxt = ST_RESP;
                else if (resp_ready[r_owner]) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .i_op     (w_op_arr[w_grant]),
        .i_a      (w_a_arr[w_grant]),
        .i_b      (w_b_arr[w_grant]),
        .o_result (w_alu_res),
        .o_err    (w_alu_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_owner  <= w_grant;
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == '0);
            r_err    <= w_alu_err;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_last_grant <= 1'b1;
        else if (w_accept) r_last_grant <= w_grant;
    end
`endif

    assign resp_result = r_result;
    assign resp_zero   = r_zero;
    assign resp_err    = r_err;

endmodule
